// File: rtl/shiftreg_rx.sv
// Serial-in, parallel-out word receiver (MSB first) with a valid/ready holding
// register and sticky overrun / framing-error flags.
`timescale 1ns/1ps
module shiftreg_rx #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    cnt,
  output logic             overrun,
  output logic             align_err,
  input  logic             err_clr
);

  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             aln_q, aln_d;

  logic             acc_start, acc_shift, complete, drain;
  logic [WIDTH-1:0] word;

  assign acc_start = sin_valid && start;
  assign acc_shift = sin_valid && !start;
  assign complete  = acc_shift && (cnt_q == CW'(WIDTH - 1));
  assign drain     = vld_q && out_ready;
  assign word      = {sr_q, sin};

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    out_d = out_q;
    vld_d = vld_q;
    ovr_d = err_clr ? 1'b0 : ovr_q;
    aln_d = err_clr ? 1'b0 : aln_q;

    if (acc_start) begin
      // A start marker always opens a fresh word; any partial bits are dropped.
      sr_d    = '0;
      sr_d[0] = sin;
      cnt_d   = CW'(1);
      if (cnt_q != '0) aln_d = 1'b1;
    end else if (acc_shift) begin
      sr_d  = word[WIDTH-2:0];
      cnt_d = complete ? '0 : cnt_q + CW'(1);
    end

    if (complete && (!vld_q || out_ready)) begin
      out_d = word;
      vld_d = 1'b1;
    end else if (complete) begin
      ovr_d = 1'b1;
    end else if (drain) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
      aln_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
      aln_q <= aln_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign cnt       = cnt_q;
  assign overrun   = ovr_q;
  assign align_err = aln_q;

endmodule
